bbox_scan_engine: RTL
=====================

BBOX_SCAN_ENGINE -- requirements
Module: bbox_scan_engine

Interface
REQ-001 The parameter list SHALL be exactly: H_RES, default 640, frame width in pixels; V_RES, default 480, frame height in lines; COORD_W, default 10, coordinate width (2^COORD_W > max(H_RES, V_RES)); ADDR_W, default 19, address width (2^ADDR_W >= H_RES*V_RES); PIX_W, default 10, pixel width; THRESH, default 512, foreground threshold; FG_POL, default 1, 1 means foreground is pix_in >= THRESH and 0 means foreground is pix_in < THRESH; MIN_W, default 4, minimum accepted box width; MIN_H, default 4, minimum accepted box height.
REQ-002 The ports SHALL be, in this order:
clk  in  1  the single clock; every register is rising-edge.
rst  in  1  reset; asynchronous, active-low.
start  in  1  one-cycle request to begin a frame scan.
abort  in  1  synchronous cancel of the scan in progress.
en  in  1  scan enable; while low, address generation stalls.
addr  out  ADDR_W  pixel address, row*H_RES+col.
addr_valid  out  1  addr is a new read request this cycle.
pix_in  in  PIX_W  pixel data; returns one cycle after its address.
busy  out  1  a scan is in progress.
o_done  out  1  one-cycle pulse: the results are updated.
o_found  out  1  a box meeting MIN_W/MIN_H was found.
o_top, o_bottom  out  COORD_W each  box row bounds, inclusive.
o_left, o_right  out  COORD_W each  box column bounds, inclusive.

Function
REQ-003 The FSM SHALL have three states: IDLE, SCAN and FINISH.
REQ-004 In IDLE, start=1 SHALL move the FSM to SCAN, clear the internal row/col counters to 0, and load the accumulators as min_row=V_RES-1, max_row=0, min_col=H_RES-1, max_col=0, any_fg=0.
REQ-005 In SCAN, with en=1, the block SHALL drive addr_valid=1 and addr=row*H_RES+col each cycle, then advance col; when col wraps from H_RES-1 to 0, row SHALL increment.
REQ-006 In SCAN, with en=0, the block SHALL drive addr_valid=0 and hold row, col and addr.
REQ-007 A one-stage pipeline SHALL register addr_valid, row and col so that pix_in sampled in cycle k+1 is matched to the address issued in cycle k.
REQ-008 A matched pixel that is foreground per FG_POL/THRESH SHALL update min_row, max_row, min_col and max_col with unsigned compares and SHALL set any_fg.
REQ-009 After issuing address H_RES*V_RES-1, the FSM SHALL enter FINISH, drive addr_valid=0, and wait for the final pipelined pixel to be evaluated.
REQ-010 On the edge after the final pixel is evaluated, the block SHALL register o_top=min_row, o_bottom=max_row, o_left=min_col and o_right=max_col, pulse o_done for one cycle, and return to IDLE.
REQ-011 Latency: with en held high, o_done SHALL rise exactly H_RES*V_RES+2 rising edges after the edge that samples start.
REQ-012 o_found SHALL be 1 only if any_fg=1, (max_col-min_col+1) >= MIN_W and (max_row-min_row+1) >= MIN_H.
REQ-013 If o_found would be 0, all four coordinate outputs SHALL be 0.
REQ-014 The result outputs SHALL hold their values until the next o_done, or until reset.
REQ-015 busy SHALL be 1 in SCAN and FINISH and 0 in IDLE.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 start asserted in the o_done cycle SHALL be ignored; a new scan starts from IDLE on a later start.
REQ-018 abort=1 in SCAN or FINISH SHALL return the FSM to IDLE on the next edge, with no o_done pulse and the result outputs unchanged.
REQ-019 abort SHALL take priority over en.
REQ-020 abort in IDLE SHALL have no effect.
REQ-021 A stall (en=0) SHALL NOT drop or duplicate any pixel: the pixel for the last issued address is still evaluated on the following cycle.
REQ-022 A single foreground pixel SHALL yield top=bottom and left=right; o_found for that case then follows MIN_W/MIN_H.

Reset
REQ-023 With rst=0, asynchronously: FSM=IDLE; row, col, addr, accumulators, addr_valid, busy, o_done, o_found, o_top, o_bottom, o_left and o_right SHALL all be 0.
REQ-024 rst asserted mid-scan SHALL abandon the scan with no o_done pulse.
REQ-025 After reset deassertion, the block SHALL wait in IDLE for a start.

Verification (H_RES=8, V_RES=6, PIX_W=10, THRESH=512, FG_POL=1, MIN_W=MIN_H=2)
REQ-026 Pixels 0x3FF at rows 1..3, cols 2..5, else 0; start with en=1 -> o_done on edge 50 after start, o_found=1, top=1, bottom=3, left=2, right=5.
REQ-027 All-zero frame -> o_done on edge 50, o_found=0, all coordinates 0; the same frame with FG_POL=0 -> o_found=1, 0/5/0/7.
REQ-028 Single foreground pixel at (4,6) -> o_found=0 (size 1x1 < 2); with MIN_W=MIN_H=1 -> o_found=1, top=bottom=4, left=right=6.
REQ-029 Frame of REQ-026 with en toggled low for 3 cycles at random points -> identical result, o_done delayed by exactly the number of low cycles, and each address 0..47 issued exactly once.
REQ-030 abort at cycle 20 -> busy=0 next edge, no o_done, prior results held; start pulsed during the scan -> ignored.
REQ-031 rst low mid-scan -> all outputs 0 immediately; a fresh start then completes normally per REQ-026.

Source files
------------

// File: rtl/bbox_scan_engine.sv
// Purpose: raster-scans one H_RES x V_RES frame and reports the bounding box of foreground pixels.
// Latency: o_done rises H_RES*V_RES+2 edges after start when en is held high. Each en=0 cycle adds one edge.
// Backpressure: en=0 stalls address issue. abort or rst drops the scan without an o_done pulse.
// Ports: clk/rst (async, active-low); start/abort/en are controls; addr/addr_valid form the read request;
//        pix_in returns one cycle after addr; busy is high while scanning; o_* are the held results,
//        updated on each o_done pulse.
module bbox_scan_engine #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 10,
    parameter int THRESH  = 512,
    parameter int FG_POL  = 1,
    parameter int MIN_W   = 4,
    parameter int MIN_H   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               en,
    output logic [ADDR_W-1:0]  addr,
    output logic               addr_valid,
    input  logic [PIX_W-1:0]   pix_in,
    output logic               busy,
    output logic               o_done,
    output logic               o_found,
    output logic [COORD_W-1:0] o_top,
    output logic [COORD_W-1:0] o_bottom,
    output logic [COORD_W-1:0] o_left,
    output logic [COORD_W-1:0] o_right
);
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_RES - 1);
    localparam logic [PIX_W-1:0]   THR    = PIX_W'(THRESH);
    localparam logic [COORD_W:0]   MIN_WC = (COORD_W+1)'(MIN_W);
    localparam logic [COORD_W:0]   MIN_HC = (COORD_W+1)'(MIN_H);

    state_t             state, state_nx;
    logic [COORD_W-1:0] row, col;
    logic [ADDR_W-1:0]  addr_q;
    logic               p_vld;
    logic [COORD_W-1:0] p_row, p_col;
    logic [COORD_W-1:0] min_row, max_row, min_col, max_col;
    logic               any_fg;

    logic               start_ok, issue, last_pix, is_fg, finalize, found;
    logic [COORD_W:0]   box_w, box_h;

    // A start landing in the o_done cycle is dropped even though the FSM is already back in IDLE.
    assign start_ok = (state == IDLE) && start && !o_done;
    // abort overrides en, so no request leaves the block in the abort cycle.
    assign issue    = (state == SCAN) && en && !abort;
    assign last_pix = (row == V_LAST) && (col == H_LAST);
    assign is_fg    = (FG_POL != 0) ? (pix_in >= THR) : (pix_in < THR);
    // FINISH is left once the last pipelined pixel has been folded into the accumulators.
    assign finalize = (state == FINISH) && !abort && !p_vld;

    assign box_w = {1'b0, max_col} - {1'b0, min_col} + (COORD_W+1)'(1);
    assign box_h = {1'b0, max_row} - {1'b0, min_row} + (COORD_W+1)'(1);
    assign found = any_fg && (box_w >= MIN_WC) && (box_h >= MIN_HC);

    assign addr       = addr_q;
    assign addr_valid = issue;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = SCAN;
            SCAN:    if (abort) state_nx = IDLE;
                     else if (issue && last_pix) state_nx = FINISH;
            FINISH:  if (abort || !p_vld) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Address generation. The counters stop on the final pixel rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row    <= '0;
            col    <= '0;
            addr_q <= '0;
        end else if (start_ok) begin
            row    <= '0;
            col    <= '0;
            addr_q <= '0;
        end else if (issue && !last_pix) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (col == H_LAST) begin
                col <= '0;
                row <= row + COORD_W'(1);
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

    // One-stage tag pipeline that aligns row/col with the returning pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_vld <= 1'b0;
            p_row <= '0;
            p_col <= '0;
        end else begin
            p_vld <= issue;
            p_row <= row;
            p_col <= col;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_row <= '0;
            max_row <= '0;
            min_col <= '0;
            max_col <= '0;
            any_fg  <= 1'b0;
        end else if (start_ok) begin
            min_row <= V_LAST;
            max_row <= '0;
            min_col <= H_LAST;
            max_col <= '0;
            any_fg  <= 1'b0;
        end else if (p_vld && is_fg) begin
            if (p_row < min_row) min_row <= p_row;
            if (p_row > max_row) max_row <= p_row;
            if (p_col < min_col) min_col <= p_col;
            if (p_col > max_col) max_col <= p_col;
            any_fg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_done   <= 1'b0;
            o_found  <= 1'b0;
            o_top    <= '0;
            o_bottom <= '0;
            o_left   <= '0;
            o_right  <= '0;
        end else begin
            o_done <= finalize;
            if (finalize) begin
                o_found  <= found;
                o_top    <= found ? min_row : '0;
                o_bottom <= found ? max_row : '0;
                o_left   <= found ? min_col : '0;
                o_right  <= found ? max_col : '0;
            end
        end
    end
endmodule
